// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage, CP0 and instruction memory.
// Holds the next-PC select codes, exception codes and the IF/ID register layout.
package fetch_stage_pkg;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] PC_RESET_DEFAULT     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
    localparam int          IM_DEPTH_DEFAULT     = 4096;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '0;

    // Word-aligned and inside [lo, hi] inclusive is a legal instruction fetch.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction memory address/data plus the IF/ID outputs to decode.
interface fetch_stage_if;

    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [4:0]  d_exc;
    logic        d_valid;

    modport master (
        output im_pc,
        input  im_instr,
        output d_instr,
        output d_pc,
        output d_exc,
        output d_valid
    );

    modport slave (
        input  im_pc,
        output im_instr,
        input  d_instr,
        input  d_pc,
        input  d_exc,
        input  d_valid
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and flush; flush beats hold so an
// exception can squash a stalled instruction.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t din,
    output ifid_t dout
);

    ifid_t q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= IFID_BUBBLE;
        end else if (flush) begin
            q <= IFID_BUBBLE;
        end else if (!hold) begin
            q <= din;
        end
    end

    assign dout = q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection, fetch address check (AdEL)
// and the IF/ID register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT,
    parameter int          IM_DEPTH     = IM_DEPTH_DEFAULT,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic [1:0]    npc_sel,
    input  logic [31:0]   npc_target,
    input  logic          eret,
    input  logic [31:0]   epc,
    input  logic          int_req,
    fetch_stage_if.master bus
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_DEPTH) - 32'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_seq;
    logic        fetch_bad;
    logic        flush;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_seq    = pc_q + 32'd4;
    assign fetch_bad = fetch_addr_bad(pc_q, PC_RESET, PC_LAST);

    // Exception redirect outranks stall; eret and npc_sel wait for the stall to clear.
    always_comb begin
        pc_next = pc_q;
        if (int_req) begin
            pc_next = HANDLER_ADDR;
        end else if (!stall) begin
            if (eret) begin
                pc_next = epc;
            end else begin
                case (npc_sel)
                    NPC_SEQ:              pc_next = pc_seq;
                    NPC_BRANCH, NPC_JUMP: pc_next = npc_target;
                    default:              pc_next = pc_seq;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

    always_comb begin
        ifid_d       = IFID_BUBBLE;
        ifid_d.pc    = pc_q;
        ifid_d.valid = 1'b1;
        if (fetch_bad) begin
            ifid_d.instr = 32'd0;
            ifid_d.exc   = EXC_ADEL;
        end else begin
            ifid_d.instr = bus.im_instr;
            ifid_d.exc   = EXC_NONE;
        end
    end

    // A taken branch/jump keeps the delay slot; only eret and exceptions squash.
    assign flush = int_req || (eret && !stall);

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (stall),
        .flush (flush),
        .din   (ifid_d),
        .dout  (ifid_q)
    );

    assign bus.im_pc   = pc_q;
    assign bus.d_instr = ifid_q.instr;
    assign bus.d_pc    = ifid_q.pc;
    assign bus.d_exc   = ifid_q.exc;
    assign bus.d_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// control traffic compared against a cycle-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic [31:0] npc_target;
    logic        eret;
    logic [31:0] epc;
    logic        int_req;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] imOffset;

    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mDpc;
    logic [4:0]  mExc;
    logic        mValid;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .npc_target (npc_target),
        .eret       (eret),
        .epc        (epc),
        .int_req    (int_req),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Memory answers any address in its 16 KiB window, ignoring the low two bits.
    assign imOffset     = bus.im_pc - 32'h0000_3000;
    assign bus.im_instr = (bus.im_pc >= 32'h0000_3000 && bus.im_pc < 32'h0000_7000)
                          ? mem[imOffset[13:2]] : 32'hFFFF_FFFF;

    function automatic logic [31:0] memRead(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - 32'h0000_3000;
        if (pc >= 32'h0000_3000 && pc < 32'h0000_7000) return mem[off[13:2]];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic addrBad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " im_pc"},   bus.im_pc,          mPc);
        checkValue({tag, " d_instr"}, bus.d_instr,        mInstr);
        checkValue({tag, " d_pc"},    bus.d_pc,           mDpc);
        checkValue({tag, " d_exc"},   {27'd0, bus.d_exc}, {27'd0, mExc});
        checkValue({tag, " d_valid"}, {31'd0, bus.d_valid}, {31'd0, mValid});
    endtask

    // Drive one cycle of controls, advance the model by the same edge, sample #1 after it.
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] sel,
                                 input logic [31:0] tgt, input logic er,
                                 input logic [31:0] ep, input logic ir);
        logic isBad;
        reset = r; stall = s; npc_sel = sel; npc_target = tgt;
        eret = er; epc = ep; int_req = ir;
        if (r || ir) begin
            mPc    = r ? 32'h0000_3000 : 32'h0000_4180;
            mInstr = 32'd0; mDpc = 32'd0; mExc = 5'd0; mValid = 1'b0;
        end else if (!s) begin
            if (er) begin
                mPc    = ep;
                mInstr = 32'd0; mDpc = 32'd0; mExc = 5'd0; mValid = 1'b0;
            end else begin
                isBad  = addrBad(mPc);
                mInstr = isBad ? 32'd0 : memRead(mPc);
                mExc   = isBad ? 5'd4 : 5'd0;
                mDpc   = mPc;
                mValid = 1'b1;
                mPc    = (sel == 2'b01 || sel == 2'b10) ? tgt : mPc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r, s, er, ir;
        logic [1:0]  sel;
        logic [31:0] tgt, ep;

        for (int i = 0; i < 4096; i++) mem[i] = $urandom | 32'd1;
        mem[0] = 32'h2401_0001;
        mem[1] = 32'h2402_0002;

        applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("reset");
        checkValue("reset im_pc", bus.im_pc, 32'h0000_3000);
        checkValue("reset d_valid", {31'd0, bus.d_valid}, 32'd0);

        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("seq1");
        checkValue("seq1 im_pc", bus.im_pc, 32'h0000_3004);
        checkValue("seq1 d_pc", bus.d_pc, 32'h0000_3000);
        checkValue("seq1 d_instr", bus.d_instr, 32'h2401_0001);
        checkValue("seq1 d_valid", {31'd0, bus.d_valid}, 32'd1);
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("seq2");
        checkValue("seq2 im_pc", bus.im_pc, 32'h0000_3008);
        checkValue("seq2 d_instr", bus.d_instr, 32'h2402_0002);

        applyStimulus(0, 0, 2'b01, 32'h0000_3040, 0, 0, 0);
        checkOutput("branch");
        checkValue("branch slot d_pc", bus.d_pc, 32'h0000_3008);
        checkValue("branch im_pc", bus.im_pc, 32'h0000_3040);

        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 2'b10, 32'h0000_3100, 0, 0, 0);
            checkOutput("stall");
            checkValue("stall im_pc", bus.im_pc, 32'h0000_3040);
            checkValue("stall d_pc", bus.d_pc, 32'h0000_3008);
        end
        applyStimulus(0, 0, 2'b10, 32'h0000_3100, 0, 0, 0);
        checkOutput("unstall");
        checkValue("unstall im_pc", bus.im_pc, 32'h0000_3100);
        checkValue("unstall d_pc", bus.d_pc, 32'h0000_3040);

        applyStimulus(0, 1, 2'b00, 0, 1, 32'h0000_3020, 1);
        checkOutput("intreq");
        checkValue("intreq im_pc", bus.im_pc, 32'h0000_4180);
        checkValue("intreq d_valid", {31'd0, bus.d_valid}, 32'd0);
        checkValue("intreq d_instr", bus.d_instr, 32'd0);

        applyStimulus(0, 0, 2'b00, 0, 1, 32'h0000_3020, 0);
        checkOutput("eret");
        checkValue("eret im_pc", bus.im_pc, 32'h0000_3020);
        checkValue("eret d_valid", {31'd0, bus.d_valid}, 32'd0);
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("eret seq");
        applyStimulus(0, 0, 2'b00, 0, 1, 32'h0000_3022, 0);
        checkOutput("eret misalign");
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("misalign fetch");
        checkValue("misalign d_exc", {27'd0, bus.d_exc}, 32'd4);
        checkValue("misalign d_instr", bus.d_instr, 32'd0);
        checkValue("misalign d_pc", bus.d_pc, 32'h0000_3022);

        applyStimulus(0, 0, 2'b10, 32'h0000_6FFC, 0, 0, 0);
        checkOutput("jump last");
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("last word");
        checkValue("last d_exc", {27'd0, bus.d_exc}, 32'd0);
        checkValue("last d_instr", bus.d_instr, mem[4095]);
        checkValue("last im_pc", bus.im_pc, 32'h0000_7000);
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("past end");
        checkValue("past end d_exc", {27'd0, bus.d_exc}, 32'd4);
        checkValue("past end d_instr", bus.d_instr, 32'd0);
        checkValue("past end d_pc", bus.d_pc, 32'h0000_7000);
        applyStimulus(0, 0, 2'b10, 32'h0000_2FFC, 0, 0, 0);
        checkOutput("jump below");
        applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("below base");
        checkValue("below d_exc", {27'd0, bus.d_exc}, 32'd4);
        checkValue("below d_pc", bus.d_pc, 32'h0000_2FFC);

        applyStimulus(0, 1, 2'b00, 0, 0, 0, 0);
        checkOutput("pre reset stall");
        applyStimulus(1, 1, 2'b10, 32'h0000_5000, 1, 32'h0000_3300, 1);
        checkOutput("reset wins");
        checkValue("reset wins im_pc", bus.im_pc, 32'h0000_3000);
        checkValue("reset wins d_pc", bus.d_pc, 32'd0);

        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            ir  = ($urandom_range(0, 39) == 0);
            er  = ($urandom_range(0, 19) == 0);
            s   = ($urandom_range(0, 3) == 0);
            sel = 2'($urandom_range(0, 3));
            tgt = ($urandom_range(0, 7) == 0) ? $urandom
                  : 32'h0000_3000 + 32'd4 * 32'($urandom_range(0, 4095));
            ep  = ($urandom_range(0, 7) == 0) ? $urandom
                  : 32'h0000_3000 + 32'd4 * 32'($urandom_range(0, 4095));
            applyStimulus(r, s, sel, tgt, er, ep, ir);
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
